// File: rtl/c_bram_reader.sv
// ============================================================================
// Module   : c_bram_reader
// Purpose  : Streams a run of C words back out of the C BRAM once the update
//            pass has finished. Reads are issued against a credit count so
//            the fixed BRAM read latency is absorbed by a small
//            first-word-fall-through FIFO that feeds a valid/ready stream.
// Ports    : clk, rst (sync, active-low)
//            start_i, base_addr_i, len_i  -- run request (ignored while busy)
//            C_bram_En_o, C_bram_Addr_o   -- BRAM read port (combinational)
//            C_bram_Dout_i                -- BRAM read data, RD_LAT after En
//            out_data_o, out_valid_o, out_last_o, out_ready_i -- output stream
//            busy_o, done_o               -- run status / 1-cycle completion
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c_bram_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              C_bram_En_o,
  output logic [ADDR_W-1:0] C_bram_Addr_o,
  input  logic [DATA_W-1:0] C_bram_Dout_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int c_PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int c_OCC_W = $clog2(FIFO_D + 1);
  localparam int c_LAT_W = $clog2(RD_LAT + 1);
  localparam int c_CR_W  = $clog2(FIFO_D + RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     issued_q, issued_d;
  logic [ADDR_W:0]     popped_q, popped_d;
  logic                done_q, done_d;

  // One bit per outstanding read; the top bit marks data arriving this cycle.
  logic [RD_LAT-1:0]   infl_q;

  logic [DATA_W-1:0]   mem_q [FIFO_D];
  logic [c_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [c_OCC_W-1:0]  occ_q;

  logic [c_LAT_W-1:0]  w_infl_cnt;
  logic [c_CR_W-1:0]   w_credit_used;
  logic                w_en;
  logic                w_wr;
  logic                w_pop;
  logic                w_last;
  logic [ADDR_W:0]     w_len_m1;

  // --------------------------------------------------------------------------
  // Credit check: words already buffered plus words still in the BRAM pipe
  // must leave room in the FIFO. A pop this cycle is deliberately not counted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_infl_cnt = w_infl_cnt + c_LAT_W'(infl_q[i]);
    end
  end

  assign w_credit_used = c_CR_W'(occ_q) + c_CR_W'(w_infl_cnt);
  assign w_en          = (state_q == S_READ) && (w_credit_used < c_CR_W'(FIFO_D));
  assign w_wr          = infl_q[RD_LAT-1];
  assign w_len_m1      = len_q - {{ADDR_W{1'b0}}, 1'b1};

  assign out_valid_o   = (occ_q != '0);
  assign out_data_o    = mem_q[rd_ptr_q];
  assign w_last        = out_valid_o && (popped_q == w_len_m1);
  assign out_last_o    = w_last;
  assign w_pop         = out_valid_o && out_ready_i;

  // Address wraps naturally at 2^ADDR_W.
  assign C_bram_En_o   = w_en;
  assign C_bram_Addr_o = base_q + issued_q[ADDR_W-1:0];
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q + {{ADDR_W{1'b0}}, w_en};
    popped_d = popped_q + {{ADDR_W{1'b0}}, w_pop};
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d   = base_addr_i;
          len_d    = len_i;
          issued_d = '0;
          popped_d = '0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (w_en && (issued_q == w_len_m1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      done_q   <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // In-flight shift register
  // --------------------------------------------------------------------------
  generate
    if (RD_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk) begin
        if (!rst) begin
          infl_q <= '0;
        end else begin
          infl_q <= w_en;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk) begin
        if (!rst) begin
          infl_q <= '0;
        end else begin
          infl_q <= {infl_q[RD_LAT-2:0], w_en};
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through). Storage is not reset; emptiness is
  // carried entirely by the occupancy counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= C_bram_Dout_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (w_wr) begin
        wr_ptr_q <= (wr_ptr_q == c_PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr_q + c_PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= (rd_ptr_q == c_PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr_q + c_PTR_W'(1);
      end
      occ_q <= occ_q + c_OCC_W'(w_wr) - c_OCC_W'(w_pop);
    end
  end

  // The credit scheme guarantees a free slot for every returning word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_wr && (occ_q == c_OCC_W'(FIFO_D))));

endmodule

`default_nettype wire
